// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared state encoding and channel sizing for the 4-to-1 stream mux
package stream_mux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational round-robin pick, searching ptr+1, ptr+2, ptr+3, ptr
module rr_arbiter4
  import stream_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_req
);
  always_comb begin
    gnt_idx = '0;
    // Walk the search order backwards so the nearest requester after ptr wins
    for (int k = NUM_CH; k >= 1; k--)
      if (req[ptr + SEL_W'(k)]) gnt_idx = ptr + SEL_W'(k);
  end
  assign any_req = |req;
endmodule

// File: rtl/rr_stream_mux4.sv
// rr_stream_mux4: four packet streams merged onto one registered output under a packet-holding round-robin grant
module rr_stream_mux4
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready,
  output logic                    busy
);
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   gnt_q, gnt_d, ptr_q, ptr_d, out_sel_q, out_sel_d, arb_idx;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d, any_req;
  logic [WIDTH-1:0]   out_data_q, out_data_d, sel_data;
  logic               can_load, load, sel_last, pkt_end;

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .any_req (any_req)
  );

  assign can_load = !out_valid_q || out_ready;
  assign sel_data = in_data[gnt_q*WIDTH +: WIDTH];
  assign sel_last = in_last[gnt_q];
  assign load     = (state_q == ST_BUSY) && in_valid[gnt_q] && can_load;
  assign pkt_end  = load && sel_last;

  always_comb begin
    in_ready        = '0;
    in_ready[gnt_q] = (state_q == ST_BUSY) && can_load;
    state_d         = (state_q == ST_IDLE) ? (any_req ? ST_BUSY : ST_IDLE) : (pkt_end ? ST_IDLE : ST_BUSY);
    gnt_d           = (state_q == ST_IDLE && any_req) ? arb_idx : gnt_q;
    ptr_d           = pkt_end ? gnt_q : ptr_q;
    // A load while the old beat leaves replaces it in place, keeping full throughput
    out_valid_d     = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d      = load ? sel_data : out_data_q;
    out_last_d      = load ? sel_last : out_last_q;
    out_sel_d       = load ? gnt_q : out_sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= SEL_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == ST_BUSY);
endmodule

// File: tb/tb_rr_stream_mux4.sv
// tb_rr_stream_mux4: directed stimulus with per-channel beat queues and an in-order output scoreboard
module tb_rr_stream_mux4;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready, busy;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  always #5 clk = ~clk;

  rr_stream_mux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {int cyc; logic [1:0] sel; logic last; logic [7:0] data;} rec_t;

  int          checks = 0, failures = 0, cyc = 0, n, start;
  logic [8:0]  txq[4][$];
  logic [10:0] exp_q[$];
  rec_t        log_q[$];
  logic [3:0]  en = 4'b0000;
  logic        ordy = 1'b1;
  int          rr_seq[6] = '{0, 1, 2, 3, 0, 1};
  int          hold_seq[5] = '{3, 3, 3, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return txq[0].size() + txq[1].size() + txq[2].size() + txq[3].size() + exp_q.size();
  endfunction

  // Drive at the falling edge, then predict what the next rising edge transfers
  task automatic step();
    logic [10:0] e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = en[i] && txq[i].size() > 0;
      in_data[i*8 +: 8] = 8'h00;
      in_last[i] = 1'b0;
      if (in_valid[i]) begin
        in_data[i*8 +: 8] = txq[i][0][7:0];
        in_last[i] = txq[i][0][8];
      end
    end
    out_ready = ordy;
    #1;
    cyc++;
    chk("rdy_onehot", 32'($countones(in_ready) <= 1), 32'd1);
    if (out_valid && out_ready) begin
      log_q.push_back('{cyc, out_sel, out_last, out_data});
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("sb_beat", {21'd0, out_sel, out_last, out_data}, {21'd0, e});
      end
    end
    for (int i = 0; i < 4; i++)
      if (in_valid[i] && in_ready[i]) exp_q.push_back({2'(i), txq[i].pop_front()});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) txq[i].delete();
    exp_q.delete();
    log_q.delete();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (pending() > 0 && k < 200) begin
      step();
      k++;
    end
    chk(tag, 32'(pending()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    do_reset(2);

    en = 4'b0000;
    repeat (10) begin
      step();
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_out_sel", 32'(out_sel), 0);
    end

    en = 4'b0100;
    txq[2] = '{9'h011, 9'h022, 9'h133};
    start = cyc + 1;
    drain("t2_drain");
    chk("t2_count", 32'(log_q.size()), 3);
    chk("t2_latency", 32'(log_q[0].cyc - start), 2);
    chk("t2_back_to_back", 32'(log_q[2].cyc - log_q[0].cyc), 2);
    chk("t2_d0", {23'd0, log_q[0].last, log_q[0].data}, 32'h011);
    chk("t2_d1", {23'd0, log_q[1].last, log_q[1].data}, 32'h022);
    chk("t2_d2", {23'd0, log_q[2].last, log_q[2].data}, 32'h133);
    chk("t2_sel", 32'(log_q[1].sel), 2);
    chk("t2_busy_after", 32'(busy), 0);

    do_reset(1);
    en = 4'b1111;
    for (int c = 0; c < 4; c++) repeat (2) txq[c].push_back({1'b1, 8'hA0 + 8'(c)});
    drain("t3_drain");
    chk("t3_count", 32'(log_q.size()), 8);
    for (int j = 0; j < 6; j++) begin
      chk("t3_rr_sel", 32'(log_q[j].sel), 32'(rr_seq[j]));
      chk("t3_rr_data", 32'(log_q[j].data), 32'hA0 + 32'(rr_seq[j]));
      if (j > 0) chk("t3_rr_gap", 32'(log_q[j].cyc - log_q[j-1].cyc), 2);
    end

    do_reset(1);
    en = 4'b0010;
    ordy = 1'b0;
    txq[1] = '{9'h05A, 9'h1A5};
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 10);
    chk("t4_first_valid", 32'(out_valid), 1);
    chk("t4_stall_data", 32'(out_data), 32'h5A);
    chk("t4_stall_ready", 32'(in_ready), 0);
    repeat (4) begin
      step();
      chk("t4_stall_data", 32'(out_data), 32'h5A);
      chk("t4_stall_ready", 32'(in_ready[1]), 0);
      chk("t4_stall_valid", 32'(out_valid), 1);
    end
    ordy = 1'b1;
    drain("t4_drain");
    chk("t4_count", 32'(log_q.size()), 2);
    chk("t4_d0", 32'(log_q[0].data), 32'h5A);
    chk("t4_d1", {23'd0, log_q[1].last, log_q[1].data}, 32'h1A5);

    do_reset(1);
    txq[3] = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
    txq[0] = '{9'h10E};
    en = 4'b1000;
    repeat (2) step();
    en = 4'b1111;
    n = 0;
    while (txq[3].size() > 0 && n < 20) begin
      step();
      n++;
      chk("t5_hold_ready0", 32'(in_ready[0]), 0);
    end
    drain("t5_drain");
    chk("t5_count", 32'(log_q.size()), 5);
    for (int j = 0; j < 5; j++) chk("t5_sel", 32'(log_q[j].sel), 32'(hold_seq[j]));

    do_reset(1);
    en = 4'b0010;
    txq[1] = '{9'h0B1, 9'h0B2, 9'h1B3};
    n = 0;
    while (log_q.size() < 1 && n < 10) begin step(); n++; end
    chk("t6_first_beat", 32'(log_q[0].data), 32'hB1);
    do_reset(1);
    step();
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_in_ready", 32'(in_ready), 0);
    en = 4'b0011;
    txq[0] = '{9'h1D0};
    txq[1] = '{9'h1D1};
    drain("t6_drain");
    chk("t6_count", 32'(log_q.size()), 2);
    chk("t6_first_grant", 32'(log_q[0].sel), 0);
    chk("t6_second_grant", 32'(log_q[1].sel), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
